// File: rtl/pipelined_cla_adder_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : adder_pkg                                                       |
// | Desc     : Geometry helpers and legality check for pipelined_cla_adder.    |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package adder_pkg;

    function automatic int num_groups(input int width, input int group);
        return width / group;
    endfunction

    function automatic int groups_per_stage(input int width, input int group, input int stages);
        return num_groups(width, group) / stages;
    endfunction

    // Width must split into whole groups, and groups must split evenly over the stages.
    function automatic bit params_ok(input int width, input int group, input int stages);
        return (group > 0) && (width > 0) && ((width % group) == 0) &&
               (stages >= 1) && (stages <= (width / group)) &&
               (((width / group) % stages) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_cla_adder_cla_group.sv
// +----------------------------------------------------------------------------+
// | Module   : cla_group                                                       |
// | Desc     : GROUP-bit combinational carry-lookahead block with group G/P.   |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             gg,
    output logic             gp,
    output logic             cout
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_c;

    // Every bit carry is a flat sum of products over g/p terms, never a chain.
    always_comb begin : p_lookahead
        logic w_t;
        logic w_acc;
        w_t   = 1'b0;
        w_acc = 1'b0;
        w_g   = a & b;
        w_p   = a ^ b;
        w_c   = '0;
        gg    = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            w_acc = 1'b0;
            for (int m = 0; m < i; m++) begin
                w_t = w_g[m];
                for (int n = m + 1; n < i; n++) begin
                    w_t = w_t & w_p[n];
                end
                w_acc = w_acc | w_t;
            end
            w_t = cin;
            for (int n = 0; n < i; n++) begin
                w_t = w_t & w_p[n];
            end
            w_c[i] = w_acc | w_t;
        end
        for (int m = 0; m < GROUP; m++) begin
            w_t = w_g[m];
            for (int n = m + 1; n < GROUP; n++) begin
                w_t = w_t & w_p[n];
            end
            gg = gg | w_t;
        end
    end

    assign sum  = w_p ^ w_c;
    assign gp   = &w_p;
    assign cout = gg | (gp & cin);

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
// +----------------------------------------------------------------------------+
// | Module   : pipelined_cla_adder                                             |
// | Desc     : Pipelined carry-lookahead add/subtract with valid/ready.        |
// |            Define PIPELINED_CLA_ADDER_SATURATE_EN to clamp s on overflow.  |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    import adder_pkg::*;

    localparam int c_G    = num_groups(WIDTH, GROUP);
    localparam int c_GPS  = groups_per_stage(WIDTH, GROUP, STAGES);
    localparam int c_LAST = STAGES - 1;

    if (!params_ok(WIDTH, GROUP, STAGES)) begin : g_param_check
        $fatal(1, "pipelined_cla_adder: illegal WIDTH/GROUP/STAGES combination");
    end

    // Stage inputs (w_*) and stage registers (r_*); r_a/r_b carry the operands
    // forward so later stages still see their unprocessed upper bits.
    logic [WIDTH-1:0]  w_a     [STAGES];
    logic [WIDTH-1:0]  w_b     [STAGES];
    logic [WIDTH-1:0]  w_s     [STAGES];
    logic [WIDTH-1:0]  w_nxt_s [STAGES];
    logic [STAGES-1:0] w_ci;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_nxt_c;
    logic [STAGES-1:0] w_adv;
    logic              w_ovf;

    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic              r_ovf;

    logic [GROUP-1:0]  w_ga    [c_G];
    logic [GROUP-1:0]  w_gb    [c_G];
    logic [GROUP-1:0]  w_gsum  [c_G];
    logic              w_gci   [c_G];
    logic              w_ggen  [c_G];
    logic              w_gprop [c_G];
    logic              w_gco   [c_G];

    always_comb begin : p_stage_in
        w_a[0]  = a;
        w_b[0]  = sub ? ~b : b;
        w_s[0]  = '0;
        w_ci    = '0;
        w_v     = '0;
        w_ci[0] = sub | cin;
        w_v[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_a[k]  = r_a[k-1];
            w_b[k]  = r_b[k-1];
            w_s[k]  = r_s[k-1];
            w_ci[k] = r_c[k-1];
            w_v[k]  = r_v[k-1];
        end
    end

    always_comb begin : p_group_ops
        for (int g = 0; g < c_G; g++) begin
            w_ga[g] = w_a[g / c_GPS][g*GROUP +: GROUP];
            w_gb[g] = w_b[g / c_GPS][g*GROUP +: GROUP];
        end
    end

    // Group carry-ins within a stage, built from group G/P terms in lookahead form.
    always_comb begin : p_group_carry
        logic w_t;
        logic w_acc;
        w_t   = 1'b0;
        w_acc = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            for (int j = 0; j < c_GPS; j++) begin
                w_acc = 1'b0;
                for (int m = 0; m < j; m++) begin
                    w_t = w_ggen[k*c_GPS + m];
                    for (int n = m + 1; n < j; n++) begin
                        w_t = w_t & w_gprop[k*c_GPS + n];
                    end
                    w_acc = w_acc | w_t;
                end
                w_t = w_ci[k];
                for (int n = 0; n < j; n++) begin
                    w_t = w_t & w_gprop[k*c_GPS + n];
                end
                w_gci[k*c_GPS + j] = w_acc | w_t;
            end
        end
    end

    for (genvar g = 0; g < c_G; g++) begin : g_grp
        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a    (w_ga[g]),
            .b    (w_gb[g]),
            .cin  (w_gci[g]),
            .sum  (w_gsum[g]),
            .gg   (w_ggen[g]),
            .gp   (w_gprop[g]),
            .cout (w_gco[g])
        );
    end

    always_comb begin : p_stage_out
        for (int k = 0; k < STAGES; k++) begin
            w_nxt_s[k] = w_s[k];
            for (int j = 0; j < c_GPS; j++) begin
                w_nxt_s[k][(k*c_GPS + j)*GROUP +: GROUP] = w_gsum[k*c_GPS + j];
            end
            w_nxt_c[k] = w_gco[k*c_GPS + c_GPS - 1];
        end
    end

    // a^b^s at the MSB recovers the carry into the MSB.
    assign w_ovf = w_a[c_LAST][WIDTH-1] ^ w_b[c_LAST][WIDTH-1] ^
                   w_nxt_s[c_LAST][WIDTH-1] ^ w_nxt_c[c_LAST];

    // Stage k may advance if the result drains or any stage at or after k is empty.
    always_comb begin : p_advance
        logic w_full;
        w_full = 1'b1;
        w_adv  = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_full = 1'b1;
            for (int m = k; m < STAGES; m++) begin
                w_full = w_full & r_v[m];
            end
            w_adv[k] = out_ready | ~w_full;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_v[k] <= w_v[k];
                    if (w_v[k]) begin
                        r_a[k] <= w_a[k];
                        r_b[k] <= w_b[k];
                        r_s[k] <= w_nxt_s[k];
                        r_c[k] <= w_nxt_c[k];
                    end
                end
            end
            if (w_adv[c_LAST] && w_v[c_LAST]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_v[c_LAST];
    assign cout      = r_c[c_LAST];
    assign ovf       = r_ovf;

`ifdef PIPELINED_CLA_ADDER_SATURATE_EN
    localparam logic [WIDTH-1:0] c_SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Wrapped sign 1 means the true result overflowed upward.
    assign s = r_ovf ? (r_s[c_LAST][WIDTH-1] ? c_SMAX : c_SMIN) : r_s[c_LAST];
`else
    assign s = r_s[c_LAST];
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_pipelined_cla_adder                                          |
// | Desc     : Self-checking bench for pipelined_cla_adder (8/4/2 geometry).   |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipelined_cla_adder;

    localparam int W  = 8;
    localparam int GR = 4;
    localparam int ST = 2;
    localparam int NB = 2000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .WIDTH  (W),
        .GROUP  (GR),
        .STAGES (ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic [7:0] s_sat;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t        vecs [10];
    int          n_checks = 0;
    int          n_err    = 0;
    int          sent     = 0;
    int          recv     = 0;
    logic [9:0]  q [$];
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_out   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mcin, input logic msub);
        logic [7:0] be;
        logic [8:0] r;
        logic       c0;
        logic       ov;
        logic [7:0] rs;
        be = msub ? ~mb : mb;
        c0 = msub ? 1'b1 : mcin;
        r  = {1'b0, ma} + {1'b0, be} + {8'b0, c0};
        ov = (ma[7] == be[7]) && (r[7] != ma[7]);
        rs = r[7:0];
`ifdef PIPELINED_CLA_ADDER_SATURATE_EN
        if (ov) rs = r[7] ? 8'h7F : 8'h80;
`endif
        return {rs, r[8], ov};
    endfunction

    // One handshake cycle against the scoreboard queue; inputs already driven.
    task automatic step(input logic [9:0] exp_push);
        @(negedge clk);
        chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < ST) || out_ready});
        if (prev_stall) chk("hold_stable", {22'b0, s, cout, ovf}, {22'b0, prev_out});
        prev_stall = out_valid && !out_ready;
        prev_out   = {s, cout, ovf};
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL spurious_result: actual %0h required none", {s, cout, ovf});
            end else begin
                chk("result", {22'b0, s, cout, ovf}, {22'b0, q.pop_front()});
            end
            recv++;
        end
        if (in_valid && in_ready) begin
            q.push_back(exp_push);
            sent++;
        end
        tick();
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 8'h47, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        vecs[9] = '{8'h3C, 8'hC3, 1'b0, 1'b1, 8'h79, 8'h79, 1'b0, 1'b0};

        // Reset held two cycles with a beat offered.
        rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b1; sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) begin
            tick();
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_s", {24'b0, s}, 32'd0);
            chk("rst_cout", {31'b0, cout}, 32'd0);
            chk("rst_ovf", {31'b0, ovf}, 32'd0);
        end
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_release_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) begin
            tick();
            chk("rst_no_ghost", {31'b0, out_valid}, 32'd0);
        end

        // Directed vectors: latency exactly two cycles.
        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1;
            chk($sformatf("vec%0d_ready", i), {31'b0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1", i), {31'b0, out_valid}, 32'd0);
            tick();
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
`ifdef PIPELINED_CLA_ADDER_SATURATE_EN
            chk($sformatf("vec%0d_s", i), {24'b0, s}, {24'b0, vecs[i].s_sat});
`else
            chk($sformatf("vec%0d_s", i), {24'b0, s}, {24'b0, vecs[i].s});
`endif
            chk($sformatf("vec%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].cout});
            chk($sformatf("vec%0d_ovf", i), {31'b0, ovf}, {31'b0, vecs[i].ovf});
        end
        tick();

        // Backpressure: four beats, out_ready low in cycles 2-4.
        sent = 0; recv = 0; q.delete(); prev_stall = 1'b0;
        cin = 1'b0; sub = 1'b0;
        for (int c = 1; c <= 30 && recv < 4; c++) begin
            in_valid  = (sent < 4);
            a         = 8'(sent + 1);
            b         = 8'(sent + 1);
            out_ready = !(c >= 2 && c <= 4);
            if (c == 3) begin
                @(negedge clk);
                chk("bp_full_stall", {31'b0, in_ready}, 32'd0);
            end
            step({8'(2 * (sent + 1)), 2'b00});
        end
        in_valid = 1'b0;
        chk("bp_sent", sent, 4);
        chk("bp_recv", recv, 4);

        // Reset with two beats in flight: they must never appear.
        out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h11;
        tick();
        a = 8'h22; b = 8'h22;
        tick();
        in_valid = 1'b0;
        chk("mf_inflight", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mf_flush_valid", {31'b0, out_valid}, 32'd0);
        chk("mf_flush_s", {24'b0, s}, 32'd0);
        out_ready = 1'b1;
        repeat (4) begin
            tick();
            chk("mf_never_appears", {31'b0, out_valid}, 32'd0);
        end

        // Random valid/ready against the reference model.
        sent = 0; recv = 0; q.delete(); prev_stall = 1'b0;
        for (int cyc = 0; cyc < 20000 && (sent < NB || q.size() > 0); cyc++) begin
            in_valid  = (sent < NB) && ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step(model(a, b, cin, sub));
        end
        in_valid = 1'b0;
        chk("rand_sent", sent, NB);
        chk("rand_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
